// File: rtl/cvita_rx_pkg.sv
// rtl/cvita_rx_pkg.sv - shared types, header bit positions and error codes for the CVITA rx checker
package cvita_rx_pkg;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_TIME = 2'd1,
        S_PAY  = 2'd2
    } state_t;

    localparam int HDR_TYPE_MSB = 63;
    localparam int HDR_TYPE_LSB = 62;
    localparam int HDR_TIME_BIT = 61;
    localparam int HDR_EOB_BIT  = 60;
    localparam int HDR_SEQ_MSB  = 59;
    localparam int HDR_SEQ_LSB  = 48;
    localparam int HDR_LEN_MSB  = 47;
    localparam int HDR_LEN_LSB  = 32;
    localparam int HDR_SRC_MSB  = 31;
    localparam int HDR_SRC_LSB  = 16;
    localparam int HDR_DST_MSB  = 15;
    localparam int HDR_DST_LSB  = 0;

    localparam logic [3:0] ERR_SIZE = 4'd1;
    localparam logic [3:0] ERR_DATA = 4'd2;
    localparam logic [3:0] ERR_DEST = 4'd4;
    localparam logic [3:0] ERR_SEQ  = 4'd8;

    typedef struct packed {
        logic [1:0]  pkt_type;
        logic        has_time;
        logic        eob;
        logic [11:0] seqnum;
        logic [15:0] length;
        logic [15:0] src_sid;
        logic [15:0] dst_sid;
    } hdr_t;

endpackage

// File: rtl/cvita_hdr_unpack.sv
// rtl/cvita_hdr_unpack.sv - combinational split of a 64-bit CHDR header word into fields
module cvita_hdr_unpack
    import cvita_rx_pkg::*;
(
    input  logic [63:0] word,
    output hdr_t        hdr
);

    always_comb begin
        hdr.pkt_type = word[HDR_TYPE_MSB:HDR_TYPE_LSB];
        hdr.has_time = word[HDR_TIME_BIT];
        hdr.eob      = word[HDR_EOB_BIT];
        hdr.seqnum   = word[HDR_SEQ_MSB:HDR_SEQ_LSB];
        hdr.length   = word[HDR_LEN_MSB:HDR_LEN_LSB];
        hdr.src_sid  = word[HDR_SRC_MSB:HDR_SRC_LSB];
        hdr.dst_sid  = word[HDR_DST_MSB:HDR_DST_LSB];
    end

endmodule

// File: rtl/cvita_pkt_rx_checker.sv
// rtl/cvita_pkt_rx_checker.sv - CVITA packet sink: header parse, payload forward, error checks, counters
// Optional payload ramp check enabled by defining CVITA_RX_PATTERN_CHECK_EN.
module cvita_pkt_rx_checker
    import cvita_rx_pkg::*;
#(
    parameter int WIDTH          = 64,
    parameter int BYTES_PER_LINE = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             en,
    input  logic             clear,
    input  logic [15:0]      node_id,
    input  logic [15:0]      exp_lines,
    output logic [WIDTH-1:0] m_pay_tdata,
    output logic             m_pay_tvalid,
    output logic             m_pay_tlast,
    output logic             pkt_done,
    output logic [1:0]       hdr_pkt_type,
    output logic             hdr_has_time,
    output logic             hdr_eob,
    output logic [11:0]      hdr_seqnum,
    output logic [15:0]      hdr_length,
    output logic [15:0]      hdr_src_sid,
    output logic [15:0]      hdr_dst_sid,
    output logic [63:0]      hdr_timestamp,
    output logic [15:0]      pkt_lines,
    output logic [3:0]       pkt_err,
    output logic [31:0]      pkt_count,
    output logic [31:0]      line_count,
    output logic [31:0]      err_count
);

    if (WIDTH != 64) begin : g_width_check
        $error("cvita_pkt_rx_checker: only WIDTH=64 is supported");
    end

    state_t      state_q, state_d;
    logic [63:0] hdr_q, ts_q, fin_word, fin_ts;
    logic [15:0] lines_q, lines_inc, fin_lines;
    logic        seq_valid_q;
    logic [11:0] last_seq_q;
    logic        accept, finish;
    logic        fin_data_err, size_err, dest_err, seq_err;
    logic [3:0]  fin_err;
    logic [31:0] total, len32;
    hdr_t        fin_hdr;

    assign s_axis_tready = en;
    assign accept        = s_axis_tvalid && en;
    assign finish        = accept && s_axis_tlast;

    // A packet may end on its header beat, so the final view is taken from the live beat there.
    assign fin_word  = (state_q == S_HDR) ? s_axis_tdata : hdr_q;
    assign lines_inc = (lines_q == 16'hFFFF) ? lines_q : lines_q + 16'd1;

    cvita_hdr_unpack u_unpack (
        .word (fin_word),
        .hdr  (fin_hdr)
    );

    always_comb begin
        fin_lines = lines_q;
        fin_ts    = ts_q;
        case (state_q)
            S_HDR: begin
                fin_lines = '0;
                fin_ts    = '0;
            end
            S_TIME:  fin_ts    = s_axis_tdata;
            S_PAY:   fin_lines = lines_inc;
            default: ;
        endcase
    end

`ifdef CVITA_RX_PATTERN_CHECK_EN
    logic data_err_q, beat_bad;
    assign beat_bad     = (state_q == S_PAY) && (s_axis_tdata != {{(WIDTH-16){1'b0}}, lines_q});
    assign fin_data_err = (state_q != S_HDR) && (data_err_q || beat_bad);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_err_q <= 1'b0;
        end else if (accept) begin
            data_err_q <= fin_data_err;
        end
    end
`else
    assign fin_data_err = 1'b0;
`endif

    assign total    = 32'(fin_hdr.has_time) + 32'(fin_lines) + 32'd1;
    assign len32    = 32'(fin_hdr.length);
    assign size_err = (len32 > total * 32'(BYTES_PER_LINE)) ||
                      (len32 <= (total - 32'd1) * 32'(BYTES_PER_LINE)) ||
                      ((exp_lines != 16'd0) && (total != 32'(exp_lines)));
    assign dest_err = (fin_hdr.dst_sid != node_id);
    assign seq_err  = seq_valid_q && (fin_hdr.seqnum != last_seq_q + 12'd1);
    assign fin_err  = (size_err     ? ERR_SIZE : 4'd0) |
                      (fin_data_err ? ERR_DATA : 4'd0) |
                      (dest_err     ? ERR_DEST : 4'd0) |
                      (seq_err      ? ERR_SEQ  : 4'd0);

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                S_HDR: begin
                    if (s_axis_tlast)                    state_d = S_HDR;
                    else if (s_axis_tdata[HDR_TIME_BIT]) state_d = S_TIME;
                    else                                 state_d = S_PAY;
                end
                S_TIME:  state_d = s_axis_tlast ? S_HDR : S_PAY;
                S_PAY:   state_d = s_axis_tlast ? S_HDR : S_PAY;
                default: state_d = S_HDR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_HDR;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr_q         <= '0;
            ts_q          <= '0;
            lines_q       <= '0;
            m_pay_tdata   <= '0;
            m_pay_tvalid  <= 1'b0;
            m_pay_tlast   <= 1'b0;
            pkt_done      <= 1'b0;
            hdr_pkt_type  <= '0;
            hdr_has_time  <= 1'b0;
            hdr_eob       <= 1'b0;
            hdr_seqnum    <= '0;
            hdr_length    <= '0;
            hdr_src_sid   <= '0;
            hdr_dst_sid   <= '0;
            hdr_timestamp <= '0;
            pkt_lines     <= '0;
            pkt_err       <= '0;
            pkt_count     <= '0;
            line_count    <= '0;
            err_count     <= '0;
            seq_valid_q   <= 1'b0;
            last_seq_q    <= '0;
        end else begin
            if (accept) begin
                case (state_q)
                    S_HDR: begin
                        hdr_q   <= s_axis_tdata;
                        ts_q    <= '0;
                        lines_q <= '0;
                    end
                    S_TIME:  ts_q    <= s_axis_tdata;
                    S_PAY:   lines_q <= lines_inc;
                    default: ;
                endcase
            end

            m_pay_tvalid <= accept && (state_q == S_PAY);
            m_pay_tlast  <= finish && (state_q == S_PAY);
            if (accept && (state_q == S_PAY)) m_pay_tdata <= s_axis_tdata;

            pkt_done <= finish;
            if (finish) begin
                hdr_pkt_type  <= fin_hdr.pkt_type;
                hdr_has_time  <= fin_hdr.has_time;
                hdr_eob       <= fin_hdr.eob;
                hdr_seqnum    <= fin_hdr.seqnum;
                hdr_length    <= fin_hdr.length;
                hdr_src_sid   <= fin_hdr.src_sid;
                hdr_dst_sid   <= fin_hdr.dst_sid;
                hdr_timestamp <= fin_ts;
                pkt_lines     <= fin_lines;
                pkt_err       <= fin_err;
            end

            // clear outranks a coincident packet completion: that packet is neither counted nor tracked
            if (clear) begin
                pkt_count   <= '0;
                line_count  <= '0;
                err_count   <= '0;
                seq_valid_q <= 1'b0;
                last_seq_q  <= '0;
            end else begin
                if (accept) line_count <= line_count + 32'd1;
                if (finish) begin
                    pkt_count   <= pkt_count + 32'd1;
                    err_count   <= err_count + ((fin_err != 4'd0) ? 32'd1 : 32'd0);
                    seq_valid_q <= 1'b1;
                    last_seq_q  <= fin_hdr.seqnum;
                end
            end
        end
    end

endmodule

// File: tb/tb_cvita_pkt_rx_checker.sv
// tb/tb_cvita_pkt_rx_checker.sv - randomized self-checking bench for cvita_pkt_rx_checker
module tb_cvita_pkt_rx_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        en;
    logic        clear;
    logic [15:0] node_id;
    logic [15:0] exp_lines;
    logic [63:0] m_pay_tdata;
    logic        m_pay_tvalid;
    logic        m_pay_tlast;
    logic        pkt_done;
    logic [1:0]  hdr_pkt_type;
    logic        hdr_has_time;
    logic        hdr_eob;
    logic [11:0] hdr_seqnum;
    logic [15:0] hdr_length;
    logic [15:0] hdr_src_sid;
    logic [15:0] hdr_dst_sid;
    logic [63:0] hdr_timestamp;
    logic [15:0] pkt_lines;
    logic [3:0]  pkt_err;
    logic [31:0] pkt_count;
    logic [31:0] line_count;
    logic [31:0] err_count;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    logic [31:0] m_pkt_count, m_line_count, m_err_count;
    bit          m_seq_valid;
    int          m_last_seq;
    logic [63:0] pay[$];

    always #5 clk = ~clk;

    cvita_pkt_rx_checker #(.WIDTH(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .en            (en),
        .clear         (clear),
        .node_id       (node_id),
        .exp_lines     (exp_lines),
        .m_pay_tdata   (m_pay_tdata),
        .m_pay_tvalid  (m_pay_tvalid),
        .m_pay_tlast   (m_pay_tlast),
        .pkt_done      (pkt_done),
        .hdr_pkt_type  (hdr_pkt_type),
        .hdr_has_time  (hdr_has_time),
        .hdr_eob       (hdr_eob),
        .hdr_seqnum    (hdr_seqnum),
        .hdr_length    (hdr_length),
        .hdr_src_sid   (hdr_src_sid),
        .hdr_dst_sid   (hdr_dst_sid),
        .hdr_timestamp (hdr_timestamp),
        .pkt_lines     (pkt_lines),
        .pkt_err       (pkt_err),
        .pkt_count     (pkt_count),
        .line_count    (line_count),
        .err_count     (err_count)
    );

    function automatic logic [63:0] make_hdr(input int ptype, input int ht, input int eob,
                                              input int seq, input int len, input int src, input int dst);
        return {2'(ptype), 1'(ht), 1'(eob), 12'(seq), 16'(len), 16'(src), 16'(dst)};
    endfunction

    function automatic int next_seq();
        return (m_last_seq + 1) % 4096;
    endfunction

    task automatic model_reset();
        m_pkt_count  = 0;
        m_line_count = 0;
        m_err_count  = 0;
        m_seq_valid  = 0;
        m_last_seq   = 0;
    endtask

    task automatic check_idle_zero(input string tag);
        vectors++;
        if ({pkt_done, pkt_err, pkt_lines, hdr_timestamp, m_pay_tvalid, m_pay_tlast} !== '0 ||
            {hdr_pkt_type, hdr_has_time, hdr_eob, hdr_seqnum, hdr_length, hdr_src_sid, hdr_dst_sid} !== 64'd0 ||
            m_pay_tdata !== 64'd0) begin
            miscompares++;
            $display("FAIL %s_outputs: got done=%0b err=%0h lines=%0d hdr=%h ts=%h pay=%0b/%h/%0b want all 0",
                     tag, pkt_done, pkt_err, pkt_lines,
                     {hdr_pkt_type, hdr_has_time, hdr_eob, hdr_seqnum, hdr_length, hdr_src_sid, hdr_dst_sid},
                     hdr_timestamp, m_pay_tvalid, m_pay_tdata, m_pay_tlast);
        end
        vectors++;
        if ({pkt_count, line_count, err_count} !== 96'd0) begin
            miscompares++;
            $display("FAIL %s_counters: got %0d/%0d/%0d want 0/0/0", tag, pkt_count, line_count, err_count);
        end
    endtask

    // Sends header [+ timestamp] + pay[] and checks payload forwarding and the completion record.
    task automatic send_pkt(input logic [63:0] hdr, input logic [63:0] ts, input int want_err,
                            input bit stalls, input bit clr_last);
        logic [63:0] beats[$];
        int          ht, npay, total, len, exp_err, expect_err, first_pay;
        bit          pv, pl, acc;
        logic [63:0] pd;
        int          guard;

        ht        = int'(hdr[61]);
        npay      = pay.size();
        len       = int'(hdr[47:32]);
        first_pay = 1 + ht;
        beats.push_back(hdr);
        if (ht != 0) beats.push_back(ts);
        foreach (pay[i]) beats.push_back(pay[i]);

        total   = 1 + ht + npay;
        exp_err = 0;
        if (len > total * 8 || len <= (total - 1) * 8) exp_err |= 1;
        if (exp_lines != 0 && total != int'(exp_lines)) exp_err |= 1;
`ifdef CVITA_RX_PATTERN_CHECK_EN
        foreach (pay[i]) if (pay[i] != 64'(i)) exp_err |= 2;
`endif
        if (hdr[15:0] != node_id) exp_err |= 4;
        if (m_seq_valid && int'(hdr[59:48]) != next_seq()) exp_err |= 8;
        expect_err = (want_err >= 0) ? want_err : exp_err;

        pv = 0; pl = 0; pd = '0; guard = 0;
        for (int b = 0; b < beats.size(); b++) begin
            acc = 0;
            while (!acc) begin
                @(negedge clk);
                vectors++;
                if (m_pay_tvalid !== pv || (pv && (m_pay_tdata !== pd || m_pay_tlast !== pl))) begin
                    miscompares++;
                    $display("FAIL m_pay: got v=%0b d=%h l=%0b want v=%0b d=%h l=%0b",
                             m_pay_tvalid, m_pay_tdata, m_pay_tlast, pv, pd, pl);
                end
                s_axis_tdata = beats[b];
                s_axis_tlast = (b == beats.size() - 1);
                clear        = clr_last && (b == beats.size() - 1);
                if (stalls && guard < 200) begin
                    s_axis_tvalid = ($urandom_range(0, 3) != 0);
                    en            = ($urandom_range(0, 3) != 0);
                end else begin
                    s_axis_tvalid = 1'b1;
                    en            = 1'b1;
                end
                guard++;
                #1;
                vectors++;
                if (s_axis_tready !== en) begin
                    miscompares++;
                    $display("FAIL tready: got %0b want %0b", s_axis_tready, en);
                end
                acc = s_axis_tvalid && en;
                pv  = acc && (b >= first_pay);
                pd  = beats[b];
                pl  = pv && (b == beats.size() - 1);
                @(posedge clk);
            end
        end

        m_line_count += 32'(beats.size());
        m_pkt_count  += 1;
        if (expect_err != 0) m_err_count += 1;
        m_seq_valid = 1;
        m_last_seq  = int'(hdr[59:48]);
        if (clr_last) model_reset();

        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        clear         = 1'b0;
        en            = 1'b1;
        vectors++;
        if (m_pay_tvalid !== pv || (pv && (m_pay_tdata !== pd || m_pay_tlast !== pl))) begin
            miscompares++;
            $display("FAIL m_pay_last: got v=%0b d=%h l=%0b want v=%0b d=%h l=%0b",
                     m_pay_tvalid, m_pay_tdata, m_pay_tlast, pv, pd, pl);
        end
        vectors++;
        if (pkt_done !== 1'b1) begin
            miscompares++;
            $display("FAIL pkt_done: got %0b want 1", pkt_done);
        end
        vectors++;
        if (pkt_err !== 4'(expect_err)) begin
            miscompares++;
            $display("FAIL pkt_err: got %0h want %0h", pkt_err, expect_err);
        end
        vectors++;
        if (pkt_lines !== 16'(npay)) begin
            miscompares++;
            $display("FAIL pkt_lines: got %0d want %0d", pkt_lines, npay);
        end
        vectors++;
        if ({hdr_pkt_type, hdr_has_time, hdr_eob, hdr_seqnum, hdr_length, hdr_src_sid, hdr_dst_sid} !== hdr) begin
            miscompares++;
            $display("FAIL hdr_fields: got %h want %h",
                     {hdr_pkt_type, hdr_has_time, hdr_eob, hdr_seqnum, hdr_length, hdr_src_sid, hdr_dst_sid}, hdr);
        end
        vectors++;
        if (hdr_timestamp !== ((ht != 0) ? ts : 64'd0)) begin
            miscompares++;
            $display("FAIL hdr_timestamp: got %h want %h", hdr_timestamp, (ht != 0) ? ts : 64'd0);
        end
        vectors++;
        if (pkt_count !== m_pkt_count || line_count !== m_line_count || err_count !== m_err_count) begin
            miscompares++;
            $display("FAIL counters: got %0d/%0d/%0d want %0d/%0d/%0d",
                     pkt_count, line_count, err_count, m_pkt_count, m_line_count, m_err_count);
        end
        @(negedge clk);
        vectors++;
        if (pkt_done !== 1'b0 || pkt_err !== 4'(expect_err)) begin
            miscompares++;
            $display("FAIL done_hold: got done=%0b err=%0h want done=0 err=%0h", pkt_done, pkt_err, expect_err);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        vectors++;
        if ({pkt_count, line_count, err_count} !== 96'd0) begin
            miscompares++;
            $display("FAIL clear_counters: got %0d/%0d/%0d want 0/0/0", pkt_count, line_count, err_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; clear = 1'b0;
        s_axis_tdata = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
        node_id = 16'd5; exp_lines = 16'd0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        vectors++;
        if (s_axis_tready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tready: got %0b want 0", s_axis_tready);
        end
        rst = 1'b1; en = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_basic();
        exp_lines = 16'd5;
        pay = '{64'd0, 64'd1, 64'd2};
        send_pkt(make_hdr(0, 1, 0, 0, 40, 16'h0010, 5), 64'h1122_3344_5566_7788, 0, 0, 0);
    endtask

    task automatic test_dest();
        pay = '{64'd0, 64'd1, 64'd2};
        send_pkt(make_hdr(0, 1, 0, next_seq(), 40, 16'h0010, 6), 64'hA5A5_0000_FFFF_0001, 4, 0, 0);
    endtask

    task automatic test_seq();
        exp_lines = 16'd0;
        pulse_clear();
        pay = '{64'd0};
        send_pkt(make_hdr(0, 0, 0, 0, 16, 1, 5), 64'd0, 0, 0, 0);
        send_pkt(make_hdr(0, 0, 0, 2, 16, 1, 5), 64'd0, 8, 0, 0);
        pulse_clear();
        send_pkt(make_hdr(0, 0, 0, 7, 16, 1, 5), 64'd0, 0, 0, 0);
    endtask

    task automatic test_hdr_only();
        pay.delete();
        exp_lines = 16'd0;
        send_pkt(make_hdr(1, 0, 1, next_seq(), 8, 2, 5), 64'd0, 0, 0, 0);
        exp_lines = 16'd5;
        send_pkt(make_hdr(1, 0, 1, next_seq(), 8, 2, 5), 64'd0, 1, 0, 0);
        exp_lines = 16'd0;
    endtask

    task automatic test_pattern();
        exp_lines = 16'd5;
        pay = '{64'd0, 64'd1, 64'd9};
`ifdef CVITA_RX_PATTERN_CHECK_EN
        send_pkt(make_hdr(0, 1, 0, next_seq(), 40, 3, 5), 64'd77, 2, 0, 0);
`else
        send_pkt(make_hdr(0, 1, 0, next_seq(), 40, 3, 5), 64'd77, 0, 0, 0);
`endif
        exp_lines = 16'd0;
    endtask

    task automatic test_clear_on_done();
        pay = '{64'd0, 64'd1};
        send_pkt(make_hdr(0, 0, 0, next_seq(), 24, 4, 5), 64'd0, 0, 0, 1);
        send_pkt(make_hdr(0, 0, 0, 100, 24, 4, 5), 64'd0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        logic [63:0] mid[3];
        mid[0] = make_hdr(0, 1, 0, next_seq(), 40, 9, 5);
        mid[1] = 64'hDEAD_BEEF_0000_0001;
        mid[2] = 64'd0;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            s_axis_tdata = mid[b]; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1; en = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        rst = 1'b0;
        #1;
        check_idle_zero("reset_mid");
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        exp_lines = 16'd5;
        pay = '{64'd0, 64'd1, 64'd2};
        send_pkt(make_hdr(0, 1, 0, 0, 40, 16'h0010, 5), 64'h0102_0304_0506_0708, 0, 0, 0);
        exp_lines = 16'd0;
    endtask

    task automatic test_random();
        int ht, npay, total, len, seq, dst, el;
        node_id = 16'($urandom);
        for (int n = 0; n < 40; n++) begin
            ht    = int'($urandom_range(0, 1));
            npay  = int'($urandom_range(0, 6));
            total = 1 + ht + npay;
            len   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 80)) : total * 8 - int'($urandom_range(0, 7));
            dst   = ($urandom_range(0, 4) == 0) ? int'(node_id ^ 16'h0001) : int'(node_id);
            seq   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4095)) : next_seq();
            case ($urandom_range(0, 2))
                0:       el = 0;
                1:       el = total;
                default: el = int'($urandom_range(1, 9));
            endcase
            exp_lines = 16'(el);
            pay.delete();
            for (int i = 0; i < npay; i++)
                pay.push_back(($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : 64'(i));
            send_pkt(make_hdr(int'($urandom_range(0, 3)), ht, int'($urandom_range(0, 1)), seq, len,
                              int'($urandom_range(0, 65535)), dst),
                     {$urandom, $urandom}, -1, 1, 0);
        end
        exp_lines = 16'd0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dest();
        test_seq();
        test_hdr_only();
        test_pattern();
        test_clear_on_done();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
